// File: rtl/uart_pkg.sv
// Shared types for the configurable UART transmitter: FSM state encoding and parity modes.
package uart_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop
   } tx_state_e;

   localparam logic ParityEven = 1'b0;
   localparam logic ParityOdd  = 1'b1;

   // data_xor is the XOR reduction of the data bits.
   function automatic logic parity_bit(input logic data_xor, input logic mode);
      return data_xor ^ (mode == ParityOdd);
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO for the transmit path; pushes into a full FIFO and pops from an empty
// FIFO are ignored.
module uart_tx_fifo #(
   parameter int unsigned Width = 8,
   parameter int unsigned Depth = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [Width-1:0]         push_data,
   output logic                     full,
   input  logic                     pop,
   output logic [Width-1:0]         pop_data,
   output logic                     empty,
   output logic [$clog2(Depth):0]   count
);

   localparam int unsigned PtrW = $clog2(Depth);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [PtrW:0]    count_q;
   logic             do_push, do_pop;

   assign full     = (count_q == (PtrW+1)'(Depth));
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign pop_data = mem_q[rd_ptr_q];
   assign do_push  = push & ~full;
   assign do_pop   = pop & ~empty;

   // Pointers wrap naturally since Depth is a power of two.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (do_push && !do_pop) begin
            count_q <= count_q + 1'b1;
         end else if (!do_push && do_pop) begin
            count_q <= count_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: buffered words are serialised as start, data (LSB first),
// optional parity and stop bits on a registered, idle-high line.
module uart_tx_cfg
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 8,
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned PARITY_EN    = 0,
   parameter int unsigned PARITY_ODD   = 0,
   parameter int unsigned STOP_BITS    = 1,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          valid_in,
   output logic                          ready_out,
   input  logic [DATA_BITS-1:0]          data_in,
   input  logic                          tx_start,
   output logic                          tx_data,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned BitW  = $clog2(DATA_BITS);
   localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
   localparam logic [BitW-1:0]  DataLast = BitW'(DATA_BITS - 1);
   localparam logic [BitW-1:0]  StopLast = BitW'(STOP_BITS - 1);
   localparam logic             ParityMode = (PARITY_ODD != 0) ? ParityOdd : ParityEven;

   tx_state_e            state_q, state_d;
   logic [BaudW-1:0]     baud_q, baud_d;
   logic [BitW-1:0]      bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 parity_q, parity_d;
   logic                 tx_q, tx_d;

   logic                 fifo_full, fifo_empty, fifo_pop;
   logic [DATA_BITS-1:0] fifo_rdata;
   logic                 baud_last, frame_end, launch;

   uart_tx_fifo #(
      .Width (DATA_BITS),
      .Depth (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (valid_in),
      .push_data (data_in),
      .full      (fifo_full),
      .pop       (fifo_pop),
      .pop_data  (fifo_rdata),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign ready_out = ~fifo_full;
   assign tx_data   = tx_q;
   assign busy      = (state_q != StIdle);

   assign baud_last = (baud_q == BaudLast);
   assign frame_end = (state_q == StStop) && baud_last && (bit_q == StopLast);
   // Launching from the final stop cycle keeps back-to-back frames gapless.
   assign launch    = tx_start && !fifo_empty && ((state_q == StIdle) || frame_end);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         parity_q <= 1'b0;
         tx_q     <= 1'b1;
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         parity_q <= parity_d;
         tx_q     <= tx_d;
      end
   end

   // tx_d is the line level for the state being entered, so tx_data is a clean register.
   always_comb begin
      state_d  = state_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      parity_d = parity_q;
      tx_d     = tx_q;
      fifo_pop = 1'b0;

      unique case (state_q)
         StIdle: begin
            tx_d = 1'b1;
         end
         StStart: begin
            if (baud_last) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = StData;
               tx_d    = shift_q[0];
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         StData: begin
            if (baud_last) begin
               baud_d = '0;
               if (bit_q == DataLast) begin
                  bit_d = '0;
                  if (PARITY_EN != 0) begin
                     state_d = StParity;
                     tx_d    = parity_q;
                  end else begin
                     state_d = StStop;
                     tx_d    = 1'b1;
                  end
               end else begin
                  bit_d   = bit_q + 1'b1;
                  shift_d = shift_q >> 1;
                  tx_d    = shift_q[1];
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         StParity: begin
            if (baud_last) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = StStop;
               tx_d    = 1'b1;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         StStop: begin
            tx_d = 1'b1;
            if (baud_last) begin
               baud_d = '0;
               if (bit_q == StopLast) begin
                  bit_d   = '0;
                  state_d = StIdle;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
            tx_d    = 1'b1;
         end
      endcase

      if (launch) begin
         fifo_pop = 1'b1;
         state_d  = StStart;
         baud_d   = '0;
         bit_d    = '0;
         shift_d  = fifo_rdata;
         parity_d = parity_bit(^fifo_rdata, ParityMode);
         tx_d     = 1'b0;
      end
   end

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 8, clock cycles per serial bit (legal 2..256).
REQ-002 The block SHALL have parameter DATA_BITS, default 8, data bits per frame (legal 5..9).
REQ-003 The block SHALL have parameter PARITY_EN, default 0, 1 = parity bit appended after data.
REQ-004 The block SHALL have parameter PARITY_ODD, default 0, 1 = odd parity, 0 = even; ignored when PARITY_EN=0.
REQ-005 The block SHALL have parameter STOP_BITS, default 1, stop bits per frame (legal 1 or 2).
REQ-006 The block SHALL have parameter FIFO_DEPTH, default 4, transmit buffer entries (power of 2, legal 2..16).
REQ-007 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-008 The block SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-009 The block SHALL have port valid_in, input, 1, write request for data_in.
REQ-010 The block SHALL have port ready_out, output, 1, high when the FIFO can accept a word.
REQ-011 The block SHALL have port data_in, input, DATA_BITS, word to transmit.
REQ-012 The block SHALL have port tx_start, input, 1, transmit enable; a new frame starts only while it is high.
REQ-013 The block SHALL have port tx_data, output, 1, registered serial line, idle high.
REQ-014 The block SHALL have port busy, output, 1, high while a frame is in progress.
REQ-015 The block SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1, number of words buffered.

Function
REQ-016 The block SHALL write data_in into the FIFO on a rising edge when valid_in and ready_out are both high.
REQ-017 ready_out SHALL equal (fifo_count != FIFO_DEPTH), computed combinationally from the current count; a pop in the same cycle does not raise it.
REQ-018 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-019 From IDLE (or the last STOP cycle), when the FIFO is non-empty and tx_start is high, the FSM SHALL pop one word and enter START at the next edge.
REQ-020 Each of START, DATA (per bit), PARITY and STOP (per bit) SHALL drive tx_data for exactly CLKS_PER_BIT cycles.
REQ-021 The frame SHALL be: START drives 0; DATA drives bits LSB first; PARITY drives the XOR of the data bits, inverted if PARITY_ODD; STOP drives 1.
REQ-022 PARITY SHALL be skipped entirely when PARITY_EN=0.
REQ-023 Frame length SHALL be CLKS_PER_BIT*(1+DATA_BITS+PARITY_EN+STOP_BITS) cycles.
REQ-024 Latency: for a word written at edge k into an empty FIFO with tx_start high in IDLE, tx_data SHALL go low at edge k+1.
REQ-025 Back-to-back frames SHALL have no idle cycle between the last stop-bit cycle and the next start bit.
REQ-026 Deasserting tx_start mid-frame SHALL NOT abort the frame; it only blocks the next frame from starting.
REQ-027 A simultaneous push and pop SHALL leave fifo_count unchanged, and both operations SHALL take effect.
REQ-028 A write attempted while full (valid_in high, ready_out low) SHALL be dropped with no state change.
REQ-029 busy SHALL be high in every state except IDLE.
REQ-030 The baud counter SHALL wrap to 0 at CLKS_PER_BIT-1; the bit counter SHALL count data bits 0..DATA_BITS-1 and stop bits 0..STOP_BITS-1.

Reset
REQ-031 While reset is high at an edge, the block SHALL set the FSM to IDLE, tx_data=1, busy=0, fifo_count=0, ready_out=1, and clear both counters.
REQ-032 Reset asserted mid-frame SHALL abort the frame and flush the FIFO, with tx_data=1 from the next edge.

Structure
REQ-033 Package uart_pkg SHALL hold the FSM state typedef (tx_state_e) and the parity-mode constants.
REQ-034 The FIFO SHALL be a separate sub-module, uart_tx_fifo, parameterised by width and depth.
REQ-035 The FSM, counters and shift register SHALL reside in uart_tx_cfg.

Verification
REQ-036 Defaults, write 0xA5 with tx_start=1 -> line low at k+1, then 1,0,1,0,0,1,0,1, then 1; each bit 8 cycles; 80 cycles total.
REQ-037 PARITY_EN=1, PARITY_ODD=0, DATA_BITS=7, STOP_BITS=2, CLKS_PER_BIT=4, write 0x13 -> parity bit 1; frame 44 cycles.
REQ-038 Write 5 words with tx_start=0, FIFO_DEPTH=4 -> ready_out low after 4 writes, fifth write dropped, fifo_count=4.
REQ-039 Raise tx_start with 3 words queued -> 3 contiguous frames, no idle cycles between them, busy continuously high, fifo_count ends at 0.
REQ-040 Assert reset mid-DATA of 0xFF with 2 words queued -> tx_data=1 next edge, fifo_count=0, and no further frames after reset.
REQ-041 FIFO full, push while a pop occurs -> push refused (ready_out was low), fifo_count decrements by 1.
